// File: rtl/nibble_serial_alu_if.sv
// Request/response bundle between the operand issue logic, the nibble-serial ALU
// and the ALU writeback.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready are both
// high. Once valid is raised, the sender holds its payload and valid until that edge.
// A valid signal never waits on ready. Ready may be used as a plain level.
interface nibble_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_alu.sv
// Multi-cycle add/sub/signed-SLT unit. Each clock it runs one 4-bit slice through the
// two-level carry-lookahead equations, and it registers the slice carry for the next slice.
module nibble_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_alu_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             sub_q, slt_q, c_q;
  logic             cout_q, ovf_q, zero_q;
  logic [KW-1:0]    k_q;

  logic             in_ready, out_valid;
  logic             accept, last;
  logic             op_sub;

  logic [3:0]       a_s, bx, g, p, c, sum;
  logic [WIDTH-1:0] res_next, res_final, slt_word;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (state_q == RUN) && (k_q == K_LAST);
  // SUB (01) and SLT (10) both need b inverted and a carry-in of 1.
  assign op_sub = (bus.op == 2'b01) || (bus.op == 2'b10);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One slice of the lookahead adder. The carry into bit 0 is the registered carry.
  always_comb begin
    a_s = a_q[{k_q, 2'b00} +: 4];
    bx  = b_q[{k_q, 2'b00} +: 4] ^ {4{sub_q}};
    g   = a_s & bx;
    p   = a_s ^ bx;

    c[0] = g[0] | (p[0] & c_q);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_q);

    sum = p ^ {c[2:0], c_q};

    res_next = result_q;
    res_next[{k_q, 2'b00} +: 4] = sum;

    // For the MSB slice, sign of the difference XOR overflow gives the signed less-than.
    slt_word    = '0;
    slt_word[0] = sum[3] ^ (c[3] ^ c[2]);

    res_final = slt_q ? slt_word : res_next;
  end

  // Operand capture and slice-by-slice datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      slt_q    <= 1'b0;
      c_q      <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      sub_q <= op_sub;
      slt_q <= (bus.op == 2'b10);
      c_q   <= op_sub;
      k_q   <= '0;
    end else if (state_q == RUN) begin
      c_q <= c[3];
      k_q <= k_q + 1'b1;
      if (last) begin
        result_q <= res_final;
        cout_q   <= c[3];
        ovf_q    <= c[3] ^ c[2];
        zero_q   <= ~|res_final;
      end else begin
        result_q <= res_next;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu: directed corner cases, backpressure, operand hold,
// mid-operation reset and randomized ops, all checked against a plain-arithmetic model.
module tb_nibble_serial_alu;

  localparam int W   = 32;
  localparam int NIB = W / 4;
  localparam int EW  = W + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_pop = 0;
  int last_acc = 0;
  bit seen = 1'b0;
  bit rand_rdy = 1'b0;

  // expected {result, cout, overflow, zero}, with the cycle of the accepting edge alongside
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  nibble_serial_alu_if #(.WIDTH(W)) bus();

  nibble_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // reference model: plain W+1-bit arithmetic and a signed compare
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [1:0] o);
    logic           sub;
    logic [W-1:0]   yy;
    logic [W:0]     s;
    logic [W-1:0]   r;
    logic           v;
    sub = (o == 2'd1) || (o == 2'd2);
    yy  = sub ? ~y : y;
    s   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sub};
    v   = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
    if (o == 2'd2) r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
    else           r = s[W-1:0];
    return {r, s[W], v, (r == '0)};
  endfunction

  function automatic logic [EW-1:0] lit(input logic [W-1:0] r, input logic c,
                                        input logic v, input logic z);
    return {r, c, v, z};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.op = 2'($urandom_range(0, 3));
  endtask

  // driver: present a request, wait for acceptance, push the expectation
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [1:0] top,
                       input bit use_lit, input logic [EW-1:0] litv);
    int n;
    bit got;
    bus.a = ta; bus.b = tbv; bus.op = top; bus.in_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (rst_n && bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (use_lit) chk("model_pin", model(ta, tbv, top), litv);
      exp_q.push_back(use_lit ? litv : model(ta, tbv, top));
      acc_q.push_back(cyc + 1);
      last_acc = cyc + 1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
  endtask

  // wait for the scoreboard to drain, scrambling the ports while the unit is busy
  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (exp_q.size() != 0) begin
        scramble();
        bus.in_valid = 1'($urandom_range(0, 1));
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid = 1'b0;
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'd0, 64'd1);
      exp_q.delete(); acc_q.delete(); seen = 1'b0;
    end
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            chk("latency", 64'(cyc - acc_q[0]), 64'(NIB));
            seen = 1'b1;
          end
          chk("result", 64'(bus.result), 64'(e[EW-1:3]));
          chk("cout", 64'(bus.cout), 64'(e[2]));
          chk("overflow", 64'(bus.overflow), 64'(e[1]));
          chk("zero", 64'(bus.zero), 64'(e[0]));
          chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
          if (bus.out_ready) begin
            exp_q.pop_front();
            acc_q.pop_front();
            seen = 1'b0;
            last_pop = cyc;
          end
        end
      end else if (exp_q.size() != 0 && !seen && cyc > acc_q[0] + NIB) begin
        chk("latency_late", 64'(cyc - acc_q[0]), 64'(NIB));
        seen = 1'b1;
      end
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 2'd0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'({bus.cout, bus.overflow, bus.zero}), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed corner cases
    issue(32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 1, lit(32'h0000_0000, 1, 0, 1)); wait_done();
    issue(32'h8000_0000, 32'h0000_0001, 2'd1, 1, lit(32'h7FFF_FFFF, 1, 1, 0)); wait_done();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 2'd0, 1, lit(32'h8000_0000, 0, 1, 0)); wait_done();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 1, lit(32'h0000_0001, 1, 0, 0)); wait_done();
    issue(32'h8000_0000, 32'h7FFF_FFFF, 2'd2, 1, lit(32'h0000_0001, 1, 1, 0)); wait_done();
    issue(32'h0000_0005, 32'h0000_0005, 2'd2, 1, lit(32'h0000_0000, 1, 0, 1)); wait_done();
    issue(32'h0000_0001, 32'hFFFF_FFFF, 2'd2, 1, lit(32'h0000_0000, 0, 0, 1)); wait_done();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 2'd3, 1, lit(32'h0000_0000, 1, 0, 1)); wait_done();

    // backpressure: hold the result for three cycles, then one idle cycle before next accept
    bus.out_ready = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, 2'd0, 1, lit(32'h2345_6789, 0, 0, 0));
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
      scramble(); bus.in_valid = 1'($urandom_range(0, 1));
    end
    repeat (3) begin
      @(posedge clk); #1;
      scramble(); bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
    issue(32'h0000_0010, 32'h0000_0020, 2'd0, 1, lit(32'h0000_0030, 0, 0, 0));
    chk("idle_gap", 64'(last_acc - last_pop), 64'd2);
    wait_done();

    // asynchronous reset while slice 3 of a SUB is pending
    issue(32'h0000_0009, 32'h0000_0003, 2'd1, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete(); acc_q.delete(); seen = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_flags", 64'({bus.cout, bus.overflow, bus.zero}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    issue(32'h0000_0002, 32'h0000_0003, 2'd0, 1, lit(32'h0000_0005, 0, 0, 0)); wait_done();

    // randomized ops with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)), 0, '0);
      wait_done();
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Multi-cycle add/sub/SLT unit that evaluates one 4-bit slice per clock through the team's 4-bit carry-lookahead equations.
- Each slice's carry-out is registered and fed back as the next slice's carry-in.
- It is the consumer stage of the CLA: it generates G/P per nibble, applies the lookahead carries, and assembles the WIDTH-bit result and flags.
- Sits between the operand issue logic and the ALU writeback, with valid/ready on both sides.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and >= 8
NIB, WIDTH/4, number of slices (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 ADD
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  sum/difference, or SLT bit in bit 0
cout  output  1  carry out of the MSB slice
overflow  output  1  signed overflow of the add/sub
zero  output  1  result == 0

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; result=0; cout=0; overflow=0; zero=0; slice index k=0; all operand/carry registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, b, op into internal registers.
  - Set carry register c_reg=1 for SUB/SLT, 0 otherwise; set k=0; go to RUN.
- RUN:
  - in_ready=0; out_valid=0. Port a, b, op changes are ignored.
  - Each edge processes slice k using the captured operands:
    - bx = b[4k+3:4k], inverted for SUB/SLT.
    - G = a_slice & bx; P = a_slice ^ bx.
    - c[i] = G[i] | P[i]&c[i-1], fully expanded two-level lookahead, with c[-1]=c_reg.
    - sum = P ^ {c[2:0], c_reg}.
  - Write sum into result register bits [4k+3:4k]; c_reg <= c[3]; k <= k+1.
  - On the edge processing k=NIB-1:
    - cout <= c[3]; overflow <= c[3]^c[2].
    - For SLT, result <= {WIDTH-1 zeros, sum[3]^(c[3]^c[2])}.
    - zero computed on the final result value.
    - Go to DONE.
- DONE:
  - out_valid=1. result, cout, overflow and zero are held stable while out_valid=1 && !out_ready.
  - On out_ready, go to IDLE next edge.
  - in_ready stays 0 in DONE; no same-cycle accept.
- Latency: out_valid rises exactly NIB edges after the accepting edge. Throughput is one op per NIB+2 cycles minimum.
- Flags for SLT: cout and overflow report the underlying subtraction; zero reflects the SLT result.
- Flags for ADD/op 11: identical behaviour.
- Async reset during RUN or DONE aborts the operation. No out_valid is produced for the aborted request.
- in_valid deasserting before acceptance has no effect. Registers only change on accept.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, out_ready=1 -> out_valid exactly 8 edges after accept; result=0x00000000, cout=1, overflow=0, zero=1.
- SUB a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, cout=1, overflow=1, zero=0. ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, cout=0.
- SLT cases:
  - a=0xFFFFFFFF, b=0x00000001 -> result=1.
  - a=0x80000000, b=0x7FFFFFFF -> result=1 (overflow path).
  - a=5, b=5 -> result=0, zero=1.
  - a=1, b=0xFFFFFFFF -> result=0.
- Backpressure: complete ADD 0x12345678+0x11111111, hold out_ready=0 for 3 cycles -> out_valid stays 1, result=0x23456789 stable; in_ready=0 throughout; idle one cycle after out_ready=1, then accepts next request.
- Operand hold: change a/b/op on ports every cycle during RUN -> result reflects only the captured values. in_valid during RUN/DONE is not accepted (in_ready=0).
- Reset: assert rst_n=0 at slice k=3 of a SUB -> all outputs 0 and in_ready=1 immediately (async). After release, a fresh ADD 2+3 returns result=5 with 8-edge latency.
